// File: rtl/bram_port_arbiter.sv
// Two-requester round-robin front end for a single-port block RAM.
// Optional ARB_WRITE_ECHO_EN: granted writes echo wdata back on x_rvalid/x_rdata.
module bram_port_arbiter #(
  parameter int DW = 8,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_q;
  logic [DW-1:0] a_hold;
  logic [DW-1:0] b_hold;
  logic          rr;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          a_ret;
  logic          b_ret;

  always_comb begin
    a_gnt = rst_n & a_req & (~b_req | ~rr);
    b_gnt = rst_n & b_req & (~a_req | rr);
    we    = (a_gnt & a_we) | (b_gnt & b_we);
    addr  = b_gnt ? b_addr : a_addr;
    wdata = b_gnt ? b_wdata : a_wdata;
  end

`ifdef ARB_WRITE_ECHO_EN
  always_comb begin
    a_ret = a_gnt;
    b_ret = b_gnt;
  end
`else
  always_comb begin
    a_ret = a_gnt & ~a_we;
    b_ret = b_gnt & ~b_we;
  end
`endif

  // Write-first port: a write registers its own data, which feeds the echo.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
      rd_q      <= wdata;
    end else begin
      rd_q <= mem[addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr       <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_hold   <= '0;
      b_hold   <= '0;
    end else begin
      if (a_gnt) rr <= 1'b1;
      else if (b_gnt) rr <= 1'b0;
      a_rvalid <= a_ret;
      b_rvalid <= b_ret;
      if (a_rvalid) a_hold <= rd_q;
      if (b_rvalid) b_hold <= rd_q;
    end
  end

  // RAM output register is shared, so each port keeps its last word.
  always_comb begin
    a_rdata = a_rvalid ? rd_q : a_hold;
    b_rdata = b_rvalid ? rd_q : b_hold;
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed self-checking bench for bram_port_arbiter.
// Honours ARB_WRITE_ECHO_EN when defined.
module tb_bram_port_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_req = 1'b0, a_we = 1'b0;
  logic [5:0] a_addr = '0;
  logic [7:0] a_wdata = '0;
  logic       a_gnt, a_rvalid;
  logic [7:0] a_rdata;
  logic       b_req = 1'b0, b_we = 1'b0;
  logic [5:0] b_addr = '0;
  logic [7:0] b_wdata = '0;
  logic       b_gnt, b_rvalid;
  logic [7:0] b_rdata;

  int checks = 0;
  int errors = 0;

`ifdef ARB_WRITE_ECHO_EN
  localparam logic ECHO = 1'b1;
`else
  localparam logic ECHO = 1'b0;
`endif

  always #5 clk = ~clk;

  bram_port_arbiter #(.DW(8), .AW(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_gnt(a_gnt),
    .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_gnt(b_gnt),
    .b_rvalid(b_rvalid), .b_rdata(b_rdata)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    a_req = 1'b0;
    b_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic       pa, pb;
  logic [7:0] ea, eb;
  logic [5:0] na, nb;
  int         grants;

  initial begin
    // reset with both requesting
    a_req = 1'b1;
    b_req = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_a_gnt", a_gnt, 0);
    chk("rst_b_gnt", b_gnt, 0);
    chk("rst_a_rv", a_rvalid, 0);
    chk("rst_b_rv", b_rvalid, 0);
    chk("rst_a_rd", a_rdata, 8'h00);
    chk("rst_b_rd", b_rdata, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    a_req = 1'b0;
    b_req = 1'b0;

    // single write then read
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b1;
    a_addr = 6'h05; a_wdata = 8'hA5;
    #1;
    chk("wr_a_gnt", a_gnt, 1);
    chk("wr_b_gnt", b_gnt, 0);
    @(negedge clk);
    a_we = 1'b0;
    #1;
    chk("rd_a_gnt", a_gnt, 1);
    chk("wr_echo_rv", a_rvalid, ECHO);
    @(negedge clk);
    a_req = 1'b0;
    chk("rd_a_rv", a_rvalid, 1);
    chk("rd_a_rd", a_rdata, 8'hA5);
    @(negedge clk);
    chk("rd_a_rv_off", a_rvalid, 0);
    chk("rd_a_hold", a_rdata, 8'hA5);

    // contention: A,B,A,B,A then idle then B
    do_reset();
    a_req = 1'b1; a_we = 1'b0; a_addr = 6'h05;
    b_req = 1'b1; b_we = 1'b0; b_addr = 6'h00;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("rr_a%0d", i), a_gnt, (i % 2) == 0);
      chk($sformatf("rr_b%0d", i), b_gnt, (i % 2) == 1);
      @(negedge clk);
    end
    a_req = 1'b0;
    b_req = 1'b0;
    #1;
    chk("idle_a", a_gnt, 0);
    chk("idle_b", b_gnt, 0);
    @(negedge clk);
    a_req = 1'b1;
    b_req = 1'b1;
    #1;
    chk("post_idle_a", a_gnt, 0);
    chk("post_idle_b", b_gnt, 1);
    @(negedge clk);
    a_req = 1'b0;
    b_req = 1'b0;

    // cross-port coherency
    @(negedge clk);
    b_req = 1'b1; b_we = 1'b1;
    b_addr = 6'h3F; b_wdata = 8'h5A;
    #1;
    chk("x_b_gnt", b_gnt, 1);
    @(negedge clk);
    b_req = 1'b0; b_we = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 6'h3F;
    #1;
    chk("x_a_gnt", a_gnt, 1);
    chk("x_b_rv", b_rvalid, ECHO);
    if (ECHO) chk("x_b_rd", b_rdata, 8'h5A);
    @(negedge clk);
    a_req = 1'b0;
    chk("x_a_rv", a_rvalid, 1);
    chk("x_a_rd", a_rdata, 8'h5A);
    chk("x_b_rv_off", b_rvalid, 0);

    // reset mid-read; rr is 1 here after A's grant
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b0; a_addr = 6'h05;
    #1;
    chk("mr_a_gnt", a_gnt, 1);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mr_a_rv", a_rvalid, 0);
    chk("mr_a_gnt_rst", a_gnt, 0);
    b_req = 1'b1;
    rst_n = 1'b1;
    #1;
    chk("mr_a_first", a_gnt, 1);
    chk("mr_b_wait", b_gnt, 0);
    @(negedge clk);
    a_req = 1'b0;
    b_req = 1'b0;

    // prefill mem[i] = i
    for (int i = 0; i < 64; i++) begin
      a_req = 1'b1; a_we = 1'b1;
      a_addr = 6'(i); a_wdata = 8'(i);
      @(negedge clk);
    end
    a_req = 1'b0;
    a_we = 1'b0;
    do_reset();

    // throughput: alternating reads, one grant per cycle
    pa = 1'b0; pb = 1'b0;
    ea = '0; eb = '0;
    na = 6'd0; nb = 6'd1;
    grants = 0;
    for (int i = 0; i < 66; i++) begin
      chk($sformatf("tp_a_rv%0d", i), a_rvalid, pa);
      chk($sformatf("tp_b_rv%0d", i), b_rvalid, pb);
      if (pa) chk($sformatf("tp_a_rd%0d", i), a_rdata, ea);
      if (pb) chk($sformatf("tp_b_rd%0d", i), b_rdata, eb);
      pa = 1'b0;
      pb = 1'b0;
      if (i < 64) begin
        a_req = 1'b1; a_addr = na;
        b_req = 1'b1; b_addr = nb;
        #1;
        if (a_gnt) begin
          grants++;
          pa = 1'b1;
          ea = {2'b00, na};
          na = na + 6'd2;
        end
        if (b_gnt) begin
          grants++;
          pb = 1'b1;
          eb = {2'b00, nb};
          nb = nb + 6'd2;
        end
      end else begin
        a_req = 1'b0;
        b_req = 1'b0;
      end
      @(negedge clk);
    end
    chk("tp_grants", grants, 64);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
